// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter: shared refill controller between the I-cache, the D-cache
// and the single main-memory read port. The D side has fixed priority. A grant
// starts a fixed-latency block read. The block is returned on WM with a one-cycle
// ready strobe to the winning cache. Per-side grant counters are kept for
// performance analysis.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_req, i_addr       I-cache miss request (level) and miss address
//   d_req, d_addr       D-cache miss request (level) and miss address
//   mem_en, mem_addr    main-memory read enable and block-aligned address
//   mem_rdata           main-memory block, valid on the last fetch cycle
//   WM                  registered refill block shared by both caches
//   i_ready, d_ready    one-cycle refill strobes
//   busy                high whenever the controller is not idle
//   i_miss_cnt          number of I-side grants (wraps)
//   d_miss_cnt          number of D-side grants (wraps)
module cache_refill_arbiter #(
    parameter int unsigned LATENCY = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [31:0]  i_addr,
    input  logic         d_req,
    input  logic [31:0]  d_addr,
    output logic         mem_en,
    output logic [31:0]  mem_addr,
    input  logic [511:0] mem_rdata,
    output logic [511:0] WM,
    output logic         i_ready,
    output logic         d_ready,
    output logic         busy,
    output logic [31:0]  i_miss_cnt,
    output logic [31:0]  d_miss_cnt
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic               owner;   // 1 = D-cache owns the current fill
    logic [CNT_W-1:0]   cnt;

    // Offset bits within a block never reach memory.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{i_addr[5:0], d_addr[5:0]};

    // Grant, fetch sequencing and strobe generation; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            WM         <= '0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            busy       <= 1'b0;
            i_miss_cnt <= '0;
            d_miss_cnt <= '0;
        end else begin
            // Strobes are single-cycle: only the FETCH->DONE edge raises them.
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req) begin
                        owner      <= 1'b1;
                        mem_addr   <= {d_addr[31:6], 6'b0};
                        cnt        <= CNT_W'(LATENCY - 1);
                        d_miss_cnt <= d_miss_cnt + 32'd1;
                        mem_en     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end else if (i_req) begin
                        owner      <= 1'b0;
                        mem_addr   <= {i_addr[31:6], 6'b0};
                        cnt        <= CNT_W'(LATENCY - 1);
                        i_miss_cnt <= i_miss_cnt + 32'd1;
                        mem_en     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Memory data is valid only on this final fetch edge.
                        WM      <= mem_rdata;
                        mem_en  <= 1'b0;
                        d_ready <= owner;
                        i_ready <= ~owner;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Self-checking bench for cache_refill_arbiter. A transaction-level model
// predicts all outputs every cycle; directed scenarios add hand-computed checks.
module tb_cache_refill_arbiter;

    localparam int L = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, d_req;
    logic [31:0]  i_addr, d_addr;
    logic         mem_en;
    logic [31:0]  mem_addr;
    logic [511:0] mem_rdata = '0;
    logic [511:0] WM;
    logic         i_ready, d_ready, busy;
    logic [31:0]  i_miss_cnt, d_miss_cnt;

    int tests  = 0;
    int errors = 0;
    logic preset_dcnt = 1'b0;

    cache_refill_arbiter #(.LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .WM(WM), .i_ready(i_ready), .d_ready(d_ready), .busy(busy),
        .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt)
    );

    always #5 clk = ~clk;

    // Memory returns fresh junk every cycle; only the final fetch cycle matters.
    always @(negedge clk) mem_rdata = {$urandom, $urandom, $urandom, $urandom,
                                       $urandom, $urandom, $urandom, $urandom,
                                       $urandom, $urandom, $urandom, $urandom,
                                       $urandom, $urandom, $urandom, $urandom};

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one fill at a time, k counts edges since the grant.
    logic         m_active;
    int           m_k;
    logic         m_owner;
    logic [31:0]  m_addr, m_icnt, m_dcnt;
    logic [511:0] m_wm;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_k = 0; m_owner = 1'b0;
            m_addr = '0; m_icnt = '0; m_dcnt = '0; m_wm = '0;
        end else begin
            if (preset_dcnt) m_dcnt = 32'hFFFF_FFFF;
            if (m_active) begin
                m_k++;
                if (m_k == L) m_wm = mem_rdata;
                if (m_k == L + 1) m_active = 1'b0;
            end else if (d_req || i_req) begin
                m_active = 1'b1;
                m_k      = 0;
                m_owner  = d_req;
                m_addr   = (d_req ? d_addr : i_addr) & 32'hFFFF_FFC0;
                if (d_req) m_dcnt = m_dcnt + 1;
                else       m_icnt = m_icnt + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always begin
        @(posedge clk);
        #1;
        chk("busy",     busy,     m_active);
        chk("mem_en",   mem_en,   m_active && m_k < L);
        chk("d_ready",  d_ready,  m_active && m_k == L && m_owner);
        chk("i_ready",  i_ready,  m_active && m_k == L && !m_owner);
        chk("mem_addr", mem_addr, m_addr);
        chk("WM",       WM,       m_wm);
        chk("i_cnt",    i_miss_cnt, m_icnt);
        chk("d_cnt",    d_miss_cnt, m_dcnt);
    end

    // Counts sampled cycles until the chosen strobe, bounded by maxc.
    task automatic wait_ready(input logic side_d, input int maxc, output int n, output int en_n);
        logic seen;
        n = 0; en_n = 0; seen = 1'b0;
        while (!seen && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_en) en_n++;
            if (side_d ? d_ready : i_ready) seen = 1'b1;
        end
        if (!seen) begin
            tests++; errors++;
            $display("FAIL wait_ready timeout side_d=%0b after %0d cycles", side_d, n);
        end
    endtask

    int n, n2, en_n, pulses;

    initial begin
        rst = 1'b1; i_req = 0; d_req = 0; i_addr = '0; d_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        repeat (10) @(posedge clk);
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_mem_en", mem_en, 1'b0);
        chk("idle_WM", WM, '0);
        chk("idle_addr", mem_addr, 32'h0);

        // Single D miss
        @(negedge clk); d_addr = 32'h0000_1A7C; d_req = 1'b1;
        wait_ready(1'b1, 40, n, en_n);
        chk("d_latency", 32'(n), 32'd21);
        chk("d_mem_en_cycles", 32'(en_n), 32'd20);
        chk("d_mem_addr", mem_addr, 32'h0000_1A40);
        chk("d_cnt_1", d_miss_cnt, 32'd1);
        chk("i_cnt_0", i_miss_cnt, 32'd0);
        @(negedge clk); d_req = 1'b0;
        repeat (2) @(negedge clk);

        // Single I miss
        i_addr = 32'hDEAD_BEEF; i_req = 1'b1;
        wait_ready(1'b0, 40, n, en_n);
        chk("i_latency", 32'(n), 32'd21);
        chk("i_mem_addr", mem_addr, 32'hDEAD_BEC0);
        @(negedge clk); i_req = 1'b0;
        repeat (2) @(negedge clk);

        // Simultaneous misses: D first, I starts two cycles after the D strobe
        i_addr = 32'h0000_2010; d_addr = 32'h0000_3005;
        i_req = 1'b1; d_req = 1'b1;
        wait_ready(1'b1, 40, n, en_n);
        chk("sim_d_latency", 32'(n), 32'd21);
        chk("sim_addr_d", mem_addr, 32'h0000_3000);
        @(negedge clk); d_req = 1'b0;
        wait_ready(1'b0, 40, n2, en_n);
        chk("sim_i_latency", 32'(n + n2), 32'd43);
        chk("sim_addr_i", mem_addr, 32'h0000_2000);
        chk("sim_d_cnt", d_miss_cnt, 32'd2);
        chk("sim_i_cnt", i_miss_cnt, 32'd2);
        @(negedge clk); i_req = 1'b0;
        repeat (2) @(negedge clk);

        // Abort by reset mid-fetch
        d_addr = 32'h0000_5555; d_req = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_mem_en", mem_en, 1'b0);
        chk("abort_addr", mem_addr, 32'h0);
        chk("abort_d_cnt", d_miss_cnt, 32'd0);
        chk("abort_i_cnt", i_miss_cnt, 32'd0);
        @(negedge clk); rst = 1'b0; d_req = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (d_ready || i_ready) pulses++;
        end
        chk("abort_no_strobe", 32'(pulses), 32'd0);

        // Withdrawn request still completes
        @(negedge clk); d_addr = 32'h4444_0080; d_req = 1'b1;
        repeat (5) @(negedge clk);
        d_req = 1'b0;
        wait_ready(1'b1, 40, n, en_n);
        chk("wd_latency", 32'(n + 5), 32'd21);
        @(posedge clk); #1;
        chk("wd_idle", busy, 1'b0);

        // Counter wrap
        @(negedge clk);
        force dut.d_miss_cnt = 32'hFFFF_FFFF;
        preset_dcnt = 1'b1;
        @(posedge clk); #1;
        release dut.d_miss_cnt;
        preset_dcnt = 1'b0;
        @(negedge clk); d_addr = 32'h0000_0040; d_req = 1'b1;
        wait_ready(1'b1, 40, n, en_n);
        chk("wrap_cnt", d_miss_cnt, 32'h0000_0000);
        @(negedge clk); d_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
